// File: rtl/isa_pnp_rom_sequencer_if.sv
// Signal bundle between the PnP config decoder, the resource ROM and the ROM sequencer.
// The sequencer attaches through the slave modport; the decoder/ROM side uses master.
interface isa_pnp_rom_sequencer_if;
  localparam int unsigned BYTE_W = 8;

  logic              wake;
  logic              isolate_start;
  logic              iso_rd;
  logic              iso_lost;
  logic              res_rd;
  logic [BYTE_W-1:0] rom_addr;
  logic [BYTE_W-1:0] rom_data;
  logic [BYTE_W-1:0] res_data;
  logic              res_ready;
  logic              iso_drive;
  logic [BYTE_W-1:0] iso_data;
  logic              iso_done;
  logic              isolated;
  logic              busy;

  modport master (
    output wake, isolate_start, iso_rd, iso_lost, res_rd, rom_data,
    input  rom_addr, res_data, res_ready, iso_drive, iso_data, iso_done, isolated, busy
  );

  modport slave (
    input  wake, isolate_start, iso_rd, iso_lost, res_rd, rom_data,
    output rom_addr, res_data, res_ready, iso_drive, iso_data, iso_done, isolated, busy
  );
endinterface

// File: rtl/isa_pnp_rom_sequencer.sv
// ISA PnP resource ROM sequencer: serial-ID isolation shifter with LFSR checksum,
// and resource-data streamer with computed end-tag checksum.
module isa_pnp_rom_sequencer #(
  parameter logic [7:0] END_TAG_ADDR = 8'h36,
  parameter logic [7:0] LFSR_INIT    = 8'h6A
) (
  input logic                     clk,
  input logic                     rst,
  isa_pnp_rom_sequencer_if.slave  bus
);

  localparam int unsigned ID_BITS = 72;
  localparam int unsigned CNT_W   = 7;
  localparam logic [7:0]  CSUM_ADDR     = 8'h08;
  localparam logic [7:0]  END_CSUM_ADDR = END_TAG_ADDR + 8'd1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ID_BITS - 1);

  typedef enum logic [2:0] {
    SLEEP, ID_FETCH, ISOLATE, RES_FETCH, RES_READY, RES_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [7:0]         addr_q, addr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ID_BITS-1:0] sreg_q, sreg_d;
  logic [7:0]         lfsr_q, lfsr_d, lfsr_nx;
  logic [7:0]         sum_q, sum_d;
  logic [7:0]         res_data_q, res_data_d;
  logic               res_ready_q, res_ready_d;
  logic               iso_drive_q, iso_drive_d;
  logic [7:0]         iso_data_q, iso_data_d;
  logic               iso_done_q, iso_done_d;
  logic               isolated_q, isolated_d;
  logic               busy_q, busy_d;

  // Eight unrolled LFSR steps, consuming the byte LSB first.
  function automatic logic [7:0] lfsr_byte(input logic [7:0] seed, input logic [7:0] din);
    logic [7:0] s;
    s = seed;
    for (int i = 0; i < 8; i++) s = {s[0] ^ s[1] ^ din[i], s[7:1]};
    return s;
  endfunction

  assign lfsr_nx = lfsr_byte(lfsr_q, bus.rom_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SLEEP;
      phase_q     <= 1'b0;
      addr_q      <= 8'h00;
      bit_cnt_q   <= '0;
      sreg_q      <= '0;
      lfsr_q      <= LFSR_INIT;
      sum_q       <= 8'h00;
      res_data_q  <= 8'h00;
      res_ready_q <= 1'b0;
      iso_drive_q <= 1'b0;
      iso_data_q  <= 8'h00;
      iso_done_q  <= 1'b0;
      isolated_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      bit_cnt_q   <= bit_cnt_d;
      sreg_q      <= sreg_d;
      lfsr_q      <= lfsr_d;
      sum_q       <= sum_d;
      res_data_q  <= res_data_d;
      res_ready_q <= res_ready_d;
      iso_drive_q <= iso_drive_d;
      iso_data_q  <= iso_data_d;
      iso_done_q  <= iso_done_d;
      isolated_q  <= isolated_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; phase is the fetch ADDR/WAIT step or the isolation bit-pair half.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    bit_cnt_d   = bit_cnt_q;
    sreg_d      = sreg_q;
    lfsr_d      = lfsr_q;
    sum_d       = sum_q;
    res_data_d  = res_data_q;
    res_ready_d = res_ready_q;
    iso_done_d  = 1'b0;
    isolated_d  = isolated_q;

    if (bus.wake) begin
      state_d     = RES_FETCH;
      phase_d     = 1'b0;
      addr_d      = 8'h00;
      lfsr_d      = LFSR_INIT;
      sum_d       = 8'h00;
      res_ready_d = 1'b0;
    end else if (bus.isolate_start) begin
      state_d     = ID_FETCH;
      phase_d     = 1'b0;
      addr_d      = 8'h00;
      bit_cnt_d   = '0;
      lfsr_d      = LFSR_INIT;
      isolated_d  = 1'b0;
      res_ready_d = 1'b0;
    end else begin
      unique case (state_q)
        SLEEP: ;
        ID_FETCH: begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Bytes enter at the top of the 64-bit ID field so byte 0 ends at bit 0.
            phase_d      = 1'b0;
            sreg_d[63:0] = {bus.rom_data, sreg_q[63:8]};
            lfsr_d       = lfsr_nx;
            if (addr_q[2:0] == 3'd7) begin
              sreg_d[71:64] = lfsr_nx;
              state_d       = ISOLATE;
              bit_cnt_d     = '0;
            end else begin
              addr_d = addr_q + 8'd1;
            end
          end
        end
        ISOLATE: begin
          if (bus.iso_lost) begin
            state_d    = SLEEP;
            isolated_d = 1'b0;
          end else if (bus.iso_rd) begin
            if (!phase_q) begin
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              sreg_d  = {1'b0, sreg_q[ID_BITS-1:1]};
              if (bit_cnt_q == LAST_BIT) begin
                iso_done_d = 1'b1;
                isolated_d = 1'b1;
                state_d    = SLEEP;
              end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
              end
            end
          end
        end
        RES_FETCH: begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d     = 1'b0;
            state_d     = RES_READY;
            res_ready_d = 1'b1;
            if (addr_q < CSUM_ADDR) begin
              res_data_d = bus.rom_data;
              lfsr_d     = lfsr_nx;
            end else if (addr_q == CSUM_ADDR) begin
              res_data_d = lfsr_q;
            end else if (addr_q <= END_TAG_ADDR) begin
              res_data_d = bus.rom_data;
              sum_d      = sum_q + bus.rom_data;
            end else begin
              res_data_d = 8'(8'd0 - sum_q);
            end
          end
        end
        RES_READY: begin
          if (bus.res_rd) begin
            addr_d = addr_q + 8'd1;
            if (addr_q == END_CSUM_ADDR) begin
              state_d     = RES_DONE;
              res_ready_d = 1'b1;
              res_data_d  = 8'hFF;
            end else begin
              state_d     = RES_FETCH;
              phase_d     = 1'b0;
              res_ready_d = 1'b0;
            end
          end
        end
        RES_DONE: begin
          res_ready_d = 1'b1;
          res_data_d  = 8'hFF;
        end
        default: state_d = SLEEP;
      endcase
    end

    iso_drive_d = (state_d == ISOLATE) && sreg_d[0];
    iso_data_d  = (state_d != ISOLATE) ? 8'h00 : (phase_d ? 8'hAA : 8'h55);
    busy_d      = (state_d == ID_FETCH) || (state_d == RES_FETCH);
  end

  assign bus.rom_addr  = addr_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ready = res_ready_q;
  assign bus.iso_drive = iso_drive_q;
  assign bus.iso_data  = iso_data_q;
  assign bus.iso_done  = iso_done_q;
  assign bus.isolated  = isolated_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_isa_pnp_rom_sequencer.sv
// Scoreboard bench for isa_pnp_rom_sequencer: driver pushes expected isolation pairs and
// resource bytes, a negedge monitor pops and compares on each host read.
module tb_isa_pnp_rom_sequencer;

  localparam logic [7:0] END_TAG = 8'h0B;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  isa_pnp_rom_sequencer_if bus();

  isa_pnp_rom_sequencer #(.END_TAG_ADDR(END_TAG), .LFSR_INIT(8'h6A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] rom [256];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  logic [7:0] res_q [$];
  logic [8:0] iso_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy_low();
    for (int i = 0; i < 40; i++) begin
      if (!bus.busy) return;
      step();
    end
    check("busy_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10; i++) begin
      if (bus.res_ready) return;
      step();
    end
    check("ready_timeout", 32'(bus.res_ready), 32'd1);
  endtask

  // Reference serial-ID checksum over a 64-bit identifier, bit 0 first.
  function automatic logic [7:0] id_checksum(input logic [63:0] id);
    logic [7:0] l;
    l = 8'h6A;
    for (int i = 0; i < 64; i++) l = {l[1] ^ l[0] ^ id[i], l[7:1]};
    return l;
  endfunction

  // Monitor: compare whatever the card presents when the host reads.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.res_rd && bus.res_ready) begin
        if (res_q.size() == 0) begin
          n_total++;
          $display("FAIL res_unexpected: got read of %0h expected none", bus.res_data);
        end else check("res_data", 32'(bus.res_data), 32'(res_q.pop_front()));
      end
      if (bus.iso_rd) begin
        if (iso_q.size() == 0) begin
          n_total++;
          $display("FAIL iso_unexpected: got pair %0h expected none", {bus.iso_drive, bus.iso_data});
        end else check("iso_pair", 32'({bus.iso_drive, bus.iso_data}), 32'(iso_q.pop_front()));
      end
      if (bus.iso_done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"},  32'(bus.rom_addr),  32'h00);
    check({tag, "_res_data"},  32'(bus.res_data),  32'h00);
    check({tag, "_res_ready"}, 32'(bus.res_ready), 32'h0);
    check({tag, "_iso_drive"}, 32'(bus.iso_drive), 32'h0);
    check({tag, "_iso_data"},  32'(bus.iso_data),  32'h00);
    check({tag, "_iso_done"},  32'(bus.iso_done),  32'h0);
    check({tag, "_isolated"},  32'(bus.isolated),  32'h0);
    check({tag, "_busy"},      32'(bus.busy),      32'h0);
  endtask

  initial begin
    logic [7:0]  id_ck;
    logic [7:0]  exp_res [13];
    logic [63:0] id;
    logic        drv;

    bus.wake = 0; bus.isolate_start = 0; bus.iso_rd = 0; bus.iso_lost = 0; bus.res_rd = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rst = 1'b1;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Full isolation with an all-zero ID: only the checksum byte 8'hB5 is driven.
    id_ck = 8'hB5;
    bus.isolate_start = 1; step(); bus.isolate_start = 0;
    check("id_fetch_busy", 32'(bus.busy), 32'd1);
    wait_busy_low();
    for (int i = 0; i < 144; i++) begin
      drv = (i / 2 >= 64) ? id_ck[i / 2 - 64] : 1'b0;
      iso_q.push_back({drv, (i % 2 == 1) ? 8'hAA : 8'h55});
      bus.iso_rd = 1; step(); bus.iso_rd = 0;
    end
    check("iso_done_pulse", 32'(bus.iso_done), 32'd1);
    check("isolated_set",   32'(bus.isolated), 32'd1);
    step();
    check("iso_done_once",  32'(done_cnt),      32'd1);
    check("iso_done_low",   32'(bus.iso_done),  32'd0);
    check("iso_idle_data",  32'(bus.iso_data),  32'h00);

    // Asynchronous reset while fetching resource data.
    bus.wake = 1; step(); bus.wake = 0;
    check("wake_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    #2 rst = 1'b0;
    step();

    // Lost isolation after 10 reads (5 bit pairs).
    bus.isolate_start = 1; step(); bus.isolate_start = 0;
    wait_busy_low();
    for (int i = 0; i < 10; i++) begin
      iso_q.push_back({1'b0, (i % 2 == 1) ? 8'hAA : 8'h55});
      bus.iso_rd = 1; step(); bus.iso_rd = 0;
    end
    check("lost_pending_data", 32'(bus.iso_data), 32'h55);
    bus.iso_lost = 1; step(); bus.iso_lost = 0;
    check("lost_iso_drive", 32'(bus.iso_drive), 32'd0);
    check("lost_iso_data",  32'(bus.iso_data),  32'h00);
    check("lost_isolated",  32'(bus.isolated),  32'd0);
    check("lost_busy",      32'(bus.busy),      32'd0);
    step(); step(); step();
    check("lost_no_done",   32'(done_cnt),      32'd1);

    // Resource ROM image; byte 0x0C content must be ignored.
    rom[0] = 8'h01; rom[1] = 8'h23; rom[2] = 8'h45; rom[3] = 8'h67;
    rom[4] = 8'h89; rom[5] = 8'hAB; rom[6] = 8'hCD; rom[7] = 8'hEF;
    rom[8] = 8'h99; rom[9] = 8'h0A; rom[10] = 8'h10; rom[11] = 8'h79; rom[12] = 8'h33;
    id = {rom[7], rom[6], rom[5], rom[4], rom[3], rom[2], rom[1], rom[0]};
    for (int i = 0; i < 8; i++) exp_res[i] = rom[i];
    exp_res[8]  = id_checksum(id);
    exp_res[9]  = 8'h0A;
    exp_res[10] = 8'h10;
    exp_res[11] = 8'h79;
    exp_res[12] = 8'h6D;

    // Wake during isolation phase 1 aborts isolation.
    bus.isolate_start = 1; step(); bus.isolate_start = 0;
    wait_busy_low();
    iso_q.push_back({1'b1, 8'h55});
    bus.iso_rd = 1; step(); bus.iso_rd = 0;
    check("phase1_drive", 32'(bus.iso_drive), 32'd1);
    check("phase1_data",  32'(bus.iso_data),  32'hAA);
    bus.wake = 1; step(); bus.wake = 0;
    check("wake_iso_drive", 32'(bus.iso_drive), 32'd0);
    check("wake_rom_addr",  32'(bus.rom_addr),  32'h00);
    check("wake_isolated",  32'(bus.isolated),  32'd0);
    check("wake_busy2",     32'(bus.busy),      32'd1);

    for (int i = 0; i < 13; i++) begin
      wait_ready();
      res_q.push_back(exp_res[i]);
      bus.res_rd = 1; step(); bus.res_rd = 0;
      if (i == 9) begin
        check("lat_n1_ready", 32'(bus.res_ready), 32'd0);
        check("lat_n1_addr",  32'(bus.rom_addr),  32'h0A);
        step();
        check("lat_n2_ready", 32'(bus.res_ready), 32'd0);
        step();
        check("lat_n3_ready", 32'(bus.res_ready), 32'd1);
        check("lat_n3_data",  32'(bus.res_data),  32'h10);
      end
    end
    for (int i = 0; i < 2; i++) begin
      wait_ready();
      res_q.push_back(8'hFF);
      bus.res_rd = 1; step(); bus.res_rd = 0;
    end
    step();
    check("done_ready", 32'(bus.res_ready), 32'd1);
    check("done_data",  32'(bus.res_data),  32'hFF);

    // Wake and res_rd together: the read is dropped and the pointer restarts.
    bus.wake = 1; step(); bus.wake = 0;
    wait_ready();
    res_q.push_back(rom[0]);
    bus.wake = 1; bus.res_rd = 1; step(); bus.wake = 0; bus.res_rd = 0;
    check("coll_rom_addr",  32'(bus.rom_addr),  32'h00);
    check("coll_res_ready", 32'(bus.res_ready), 32'd0);
    wait_ready();
    res_q.push_back(rom[0]);
    bus.res_rd = 1; step(); bus.res_rd = 0;
    wait_ready();
    res_q.push_back(rom[1]);
    bus.res_rd = 1; step(); bus.res_rd = 0;

    step(); step(); step();
    check("res_queue_drained", 32'(res_q.size()), 32'd0);
    check("iso_queue_drained", 32'(iso_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
